// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit beside the EXE stage.
//   Signed ops run on magnitudes, and the signs are applied in a final FIX cycle.
//   Latency: XLEN RUN steps plus one FIX step. hi/lo are written at the FIX edge.
// Ports:
//   clk, rst (async, active-high)
//   start/op/rs_val/rt_val  issue MULT(00) MULTU(01) DIV(10) DIVU(11); accepted only in IDLE
//   mthi/mtlo/wdata         HI/LO moves; accepted only in IDLE when no op is issued
//   flush                   aborts an in-flight op and blocks an issue in IDLE
//   busy, done              registered status; done pulses for one cycle after completion
//   hi, lo                  architectural HI/LO registers
module mult_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_a_q, neg_a_d;   // negate product / quotient
    logic              neg_b_q, neg_b_d;   // negate remainder (dividend sign)
    logic              div0_q, div0_d;
    logic [XLEN:0]     acc_q, acc_d;       // product high half / partial remainder
    logic [XLEN-1:0]   wlo_q, wlo_d;       // multiplier / dividend, shifts into result
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand / divisor magnitude
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic              issue, move;
    logic              rs_neg, rt_neg;
    logic [XLEN-1:0]   abs_rs, abs_rt;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign issue = (state_q == IDLE) && start && !flush;
    assign move  = (state_q == IDLE) && !start && !flush;

    // State register (all flops)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            acc_q    <= '0;
            wlo_q    <= '0;
            opnd_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= div0_d;
            acc_q    <= acc_d;
            wlo_q    <= wlo_d;
            opnd_q   <= opnd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Iteration datapath
    always_comb begin
        rs_neg   = ~op[0] & rs_val[XLEN-1];
        rt_neg   = ~op[0] & rt_val[XLEN-1];
        abs_rs   = rs_neg ? -rs_val : rs_val;
        abs_rt   = rt_neg ? -rt_val : rt_val;
        mul_sum  = acc_q + (wlo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[XLEN-1:0], wlo_q[XLEN-1]};
        div_diff = rem_sh - {1'b0, opnd_q};

        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        acc_d    = acc_q;
        wlo_d    = wlo_q;
        opnd_d   = opnd_q;

        if (issue) begin
            cnt_d    = CNT_W'(XLEN);
            is_div_d = op[1];
            neg_a_d  = rs_neg ^ rt_neg;
            neg_b_d  = rs_neg;
            div0_d   = op[1] && (rt_val == '0);
            acc_d    = '0;
            opnd_d   = op[1] ? abs_rt : abs_rs;
            wlo_d    = op[1] ? abs_rs : abs_rt;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (is_div_q) begin
                // Restoring step: the quotient bit enters at the bottom of wlo.
                if (!div_diff[XLEN]) begin
                    acc_d = div_diff;
                    wlo_d = {wlo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh;
                    wlo_d = {wlo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {1'b0, mul_sum[XLEN:1]};
                wlo_d = {mul_sum[0], wlo_q[XLEN-1:1]};
            end
        end
    end

    // Output logic
    always_comb begin
        prod     = {acc_q[XLEN-1:0], wlo_q};
        prod_fix = neg_a_q ? -prod : prod;
        busy_d   = (state_d != IDLE);
        done_d   = (state_q == FIX) && !flush;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == FIX && !flush) begin
            if (is_div_q) begin
                // When dividing by zero, the remainder equals |rs|. Giving it the sign of rs restores the original rs.
                lo_d = div0_q ? '1 : (neg_a_q ? -wlo_q : wlo_q);
                hi_d = neg_b_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            end else begin
                {hi_d, lo_d} = prod_fix;
            end
        end else if (move) begin
            if (mthi) hi_d = wdata;
            if (mtlo) lo_d = wdata;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, mthi, mtlo, flush;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_val, rt_val, wdata;
    logic            busy, done;
    logic [XLEN-1:0] hi, lo;

    mult_div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on 64-bit arithmetic.
    function automatic res_t ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t            r;
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b10: begin
                if (b == 0) begin r.lo = '1; r.hi = a; end
                else begin sq = sa / sb; sr = sa % sb; r.lo = sq[31:0]; r.hi = sr[31:0]; end
            end
            default: begin
                if (b == 0) begin r.lo = '1; r.hi = a; end
                else begin p = ua / ub; r.lo = p[31:0]; p = ua % ub; r.hi = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    // Monitor: compares each done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) begin
                n_checks++;
                n_fail++;
                $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("result_hi", 64'(hi), 64'(e.hi));
                    check("result_lo", 64'(lo), 64'(e.lo));
                    model_hi = e.hi;
                    model_lo = e.lo;
                end
            end
        end
    end

    // Issue one op and count its busy cycles. 'disturb' pokes start/mthi/mtlo and scrambles inputs while the op runs.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_move, input bit disturb);
        int cnt;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (with_move) begin
            mthi  = 1'b1;
            mtlo  = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        exp_q.push_back(ref_model(o, a, b));
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            if (done) break;
            if (busy) cnt++;
            if (disturb) begin
                op     = 2'($urandom);
                rs_val = $urandom;
                rt_val = $urandom;
                if (cnt == 5) begin
                    start = 1'b1;
                    mthi  = 1'b1;
                    mtlo  = 1'b1;
                    wdata = $urandom;
                end
            end
        end
        check("latency", 64'(cnt), 64'd33);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 0; mthi = 0; mtlo = 0; flush = 0;
        op = '0; rs_val = '0; rt_val = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        // Directed cases
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(2'b11, 32'd7, 32'd0, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'd0, 0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);

        // MTHI alone, then MTHI+MTLO together
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_kept", 64'(lo), 64'(model_lo));
        check("mthi_done", 64'(done), 64'd0);
        model_hi = 32'h1234;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mtboth_hi", 64'(hi), 64'hA5A5_0F0F);
        check("mtboth_lo", 64'(lo), 64'hA5A5_0F0F);
        model_hi = 32'hA5A5_0F0F;
        model_lo = 32'hA5A5_0F0F;

        // start takes priority over a simultaneous move, and ops ignore start/moves while busy
        run_op(2'b00, 32'd5, 32'd6, 1, 1);
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 0, 1);

        // Flush during RUN
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'(model_hi));
        check("flush_lo", 64'(lo), 64'(model_lo));
        repeat (40) @(negedge clk);

        // start and flush in the same cycle
        start = 1'b1; flush = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("startflush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("startflush_hi", 64'(hi), 64'(model_hi));
        check("startflush_lo", 64'(lo), 64'(model_lo));

        // Random ops, with edge values mixed in
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(2'($urandom), a, b, 0, ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'hFFFF_0000; rt_val = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        repeat (40) @(negedge clk);

        // Issue after reset still yields an exact result
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
